// File: rtl/packetizer_pkg.sv
// Shared definitions for adc_sample_packetizer: FSM state encoding, the
// header magic word and the 14->16 bit sign-extension helper.
// Optional header feature: PACKETIZER_HEADER_EN (see adc_sample_packetizer.sv).
package packetizer_pkg;

    // IDLE: waiting for a packet start
    // FILL: collecting samples for an admitted packet
    // DROP: discarding samples until the next packet boundary
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [15:0] HDR_MAGIC = 16'hA55A;

    // Replicate the sample sign bit (bit 13) into bits 15:14.
    function automatic logic [15:0] sext16(input logic [13:0] x);
        return {{2{x[13]}}, x};
    endfunction

endpackage

// File: rtl/adc_sample_packetizer_if.sv
// Bus bundle for adc_sample_packetizer: the incoming sample strobe and the
// outgoing AXI-Stream packet port.
//
// Handshake semantics: on the sample side a sample is taken on every rising
// clk edge where s_valid is high (no back-pressure; the packetizer never
// stalls the source). On the AXI-Stream side a word transfers on every
// rising clk edge where m_tvalid and m_tready are both high; once m_tvalid
// is raised, m_tdata/m_tlast stay stable and m_tvalid stays high until that
// transfer happens.
//
// Modport slave is the packetizer's view; modport master is the view of
// the environment that feeds samples and consumes packets.
interface adc_sample_packetizer_if #(
    parameter int ADC_WIDTH  = 14,
    parameter int DATA_WIDTH = 32
) ();
    logic                  s_valid;
    logic [ADC_WIDTH-1:0]  s_data;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    modport slave (
        input  s_valid,
        input  s_data,
        output m_tdata,
        output m_tvalid,
        input  m_tready,
        output m_tlast
    );

    modport master (
        output s_valid,
        output s_data,
        input  m_tdata,
        input  m_tvalid,
        output m_tready,
        input  m_tlast
    );
endinterface

// File: rtl/packetizer_fifo.sv
// Synchronous first-word-fall-through FIFO for the packetizer output.
// The head entry is visible on pop_data whenever valid is high; pop_data
// reads as zero while empty. free reports empty entries including a pop
// happening in the current cycle, so admission can count on that slot.
module packetizer_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     free
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             pop_fire;
    logic             push_fire;

    assign valid     = (count != '0);
    assign pop_fire  = pop & valid;
    // A push into a full FIFO is accepted only when the head leaves this cycle.
    assign push_fire = push & ((count != CW'(DEPTH)) | pop_fire);
    assign pop_data  = valid ? mem[rd_ptr] : '0;
    assign free      = CW'(DEPTH) - count + {{AW{1'b0}}, pop_fire};

    // Storage write; contents need no reset because valid gates the output.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; reset flushes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_sample_packetizer.sv
// Packs pairs of 14-bit signed ADC samples into 32-bit words and emits
// fixed-length AXI-Stream packets. A packet is admitted only when the output
// FIFO has room for all of its words, so admitted packets always complete;
// samples of packets that do not fit are dropped and counted.
// Optional feature macro: PACKETIZER_HEADER_EN prepends a header word
// {HDR_MAGIC, seq} to every packet.
module adc_sample_packetizer
    import packetizer_pkg::*;
#(
    parameter int ADC_WIDTH  = 14,
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 64,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    adc_sample_packetizer_if.slave      bus,
    output logic [15:0]                 pkt_count,
    output logic [15:0]                 drop_count,
    output logic                        overflow,
    output state_t                      fsm_state
);
    localparam int IDX_W = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef PACKETIZER_HEADER_EN
    localparam int HDR_WORDS = 1;
`else
    localparam int HDR_WORDS = 0;
`endif
    localparam int NEED_WORDS = PKT_LEN / 2 + HDR_WORDS;

    state_t                 state;
    state_t                 state_n;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_n;
    logic [ADC_WIDTH-1:0]   lat;
    logic [ADC_WIDTH-1:0]   lat_n;
    logic                   push;
    logic [DATA_WIDTH:0]    push_data;
    logic                   drop;
    logic                   is_last;
    logic [DATA_WIDTH:0]    fifo_out;
    logic                   fifo_valid;
    logic [CNT_W-1:0]       free;

`ifdef PACKETIZER_HEADER_EN
    logic [15:0]            seq;
    logic                   seq_inc;
`endif

    assign is_last   = (idx == IDX_W'(PKT_LEN - 1));
    assign fsm_state = state;

    packetizer_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.m_tready),
        .pop_data  (fifo_out),
        .valid     (fifo_valid),
        .free      (free)
    );

    assign bus.m_tvalid = fifo_valid;
    assign bus.m_tdata  = fifo_out[DATA_WIDTH-1:0];
    assign bus.m_tlast  = fifo_out[DATA_WIDTH];

    // State, sample index and first-half latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            lat   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            lat   <= lat_n;
        end
    end

    // Admission, packing and drop decisions; at most one FIFO push per cycle.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        lat_n     = lat;
        push      = 1'b0;
        push_data = '0;
        drop      = 1'b0;
`ifdef PACKETIZER_HEADER_EN
        seq_inc   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.s_valid && enable) begin
                    idx_n = IDX_W'(1);
                    if (free >= CNT_W'(NEED_WORDS)) begin
                        state_n = FILL;
                        lat_n   = bus.s_data;
`ifdef PACKETIZER_HEADER_EN
                        seq_inc   = 1'b1;
                        push      = 1'b1;
                        push_data = {1'b0, HDR_MAGIC, seq};
`endif
                    end else begin
                        state_n = DROP;
                        drop    = 1'b1;
                    end
                end
            end
            FILL: begin
                if (bus.s_valid) begin
                    idx_n = idx + 1'b1;
                    if (!idx[0]) begin
                        lat_n = bus.s_data;
                    end else begin
                        push      = 1'b1;
                        push_data = {is_last, sext16(bus.s_data), sext16(lat)};
                        if (is_last) begin
                            state_n = IDLE;
                            idx_n   = '0;
                        end
                    end
                end
            end
            DROP: begin
                if (bus.s_valid) begin
                    drop  = 1'b1;
                    idx_n = idx + 1'b1;
                    if (is_last) begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    // Packet completion, drop statistics and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (bus.m_tvalid && bus.m_tready && bus.m_tlast) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

`ifdef PACKETIZER_HEADER_EN
    // Sequence number advances once per admitted packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq <= '0;
        end else if (seq_inc) begin
            seq <= seq + 16'd1;
        end
    end
`endif

endmodule

// File: doc/adc_sample_packetizer.md
# adc_sample_packetizer

Downstream consumer of the preprocessing stage output. Accepts the 14-bit signed sample stream, which arrives at one valid per `CLOCKS_PER_SAMPLE` cycles nominally but may arrive every cycle. Packs two samples per 32-bit word and emits fixed-length AXI-Stream packets to the DMA/readout path. Packets are never truncated: admission control at each packet start guarantees FIFO room for the whole packet. Samples with no room are dropped and counted.

## Interface
Parameters:
- `ADC_WIDTH`, 14, input sample width (signed)
- `DATA_WIDTH`, 32, output word width
- `PKT_LEN`, 64, samples per packet; must be even and ≥ 2
- `FIFO_DEPTH`, 64, output FIFO entries (power of 2); must be ≥ `PKT_LEN/2 + 1`

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  allow new packets to start
- `s_valid`  in  1  sample strobe
- `s_data`  in  ADC_WIDTH  signed sample
- `m_tdata`  out  DATA_WIDTH  packed word
- `m_tvalid`  out  1
- `m_tready`  in  1
- `m_tlast`  out  1  last word of packet
- `pkt_count`  out  16  packets fully handed off, wraps
- `drop_count`  out  16  samples dropped, saturates at 16'hFFFF
- `overflow`  out  1  sticky; set on first drop, cleared only by `rst`

## Operation
- FSM states, defined in the package:
  - `IDLE`: waiting for a packet start.
  - `FILL`: collecting samples for an admitted packet.
  - `DROP`: discarding samples until the next packet boundary.
- `IDLE`, `s_valid` with `enable` = 0: sample ignored, not counted.
- `IDLE`, `s_valid` with `enable` = 1:
  - FIFO free entries ≥ `PKT_LEN/2` (+1 with header): admit. Push header if configured, latch the sample as first-half, sample index ← 1, go to `FILL`.
  - Otherwise: drop the sample, set sample index ← 1, go to `DROP`.
- `FILL`:
  - Even index: latch sample into the low half.
  - Odd index: push word {sext16(sample), sext16(latched)}. Push with tlast = 1 when index = `PKT_LEN-1`, then return to `IDLE`.
  - Sign extension replicates bit 13 into bits 15:14.
- `DROP`: every `s_valid` increments `drop_count` (saturating) and sets `overflow`. At index `PKT_LEN-1`, return to `IDLE`. The next sample is re-evaluated for admission.
- Deasserting `enable` mid-packet: the current packet completes normally.
- `pkt_count` increments when `m_tvalid & m_tready & m_tlast`.
- Sequence number: increments by 1 per admitted packet and wraps at 16 bits. It is not advanced by dropped packets.
- Reset values:
  - `m_tvalid`, `m_tlast`, `overflow` = 0.
  - `pkt_count`, `drop_count`, sequence number = 0.
  - FSM = `IDLE`.
  - `m_tdata` = 0.
- Reset mid-packet flushes the FIFO; a partial packet is lost without `m_tlast`.

## Timing
- FIFO push occurs on the edge ending the cycle of the triggering `s_valid`. The word appears with `m_tvalid` = 1 in the next cycle if the FIFO was empty, so latency is 1 cycle.
- The header (first sample) and each data word (odd sample) are pushed in distinct cycles, so there is at most one push per cycle.
- Output is first-word-fall-through. `m_tdata`/`m_tlast` are held stable while `m_tvalid & !m_tready`.
- Pop and push in the same cycle are legal when the FIFO is full.
- Free-entry count is evaluated in the admission cycle and includes a same-cycle pop.
- `m_tready` low indefinitely: admitted packets still complete, because space was reserved. New packets go to `DROP`.

## Configuration
- `PACKETIZER_HEADER_EN` defined:
  - Each packet starts with the header word {16'hA55A, seq[15:0]}.
  - Packet length is `PKT_LEN/2 + 1` words.
  - Admission requires `PKT_LEN/2 + 1` free entries.
- Macro undefined: no header; packet is `PKT_LEN/2` words; sequence counter not instantiated.

## Structure
- Package `packetizer_pkg` holds:
  - FSM state enum.
  - `HDR_MAGIC` = 16'hA55A.
  - Sign-extend function for 14→16 bits.
- Sub-module `packetizer_fifo`: synchronous FWFT FIFO, width `DATA_WIDTH+1` (tlast bit), depth `FIFO_DEPTH`, with a free-entry count output.

## Test plan
- Basic packet:
  - Setup: `PKT_LEN`=8, `FIFO_DEPTH`=8, header on, `m_tready`=1, `enable`=1.
  - Stimulus: samples 1..8 at one per 3 cycles.
  - Expected: A55A0000, 00020001, 00040003, 00060005, 00080007 (tlast on the last word); `pkt_count`=1.
- Sign extension: samples 14'h1FFF, 14'h2000 → word 32'hE0001FFF.
- Backpressure:
  - Stimulus: `m_tready`=0; feed 24 samples, one per cycle.
  - Expected: packet 1 admitted (5 words); packets 2 and 3 dropped; `drop_count`=16, `overflow`=1.
  - Then raise `m_tready`: exactly 5 words out, tlast on the 5th.
- Enable: drop `enable` after sample 3 → packet of 8 completes. Further samples are ignored and `drop_count` is unchanged.
- Reset mid-packet: after 3 words are pushed, pulse `rst` → `m_tvalid`=0 next cycle, all counters 0. The next packet header has seq 0000.
- Header off (macro undefined): same stimulus as basic packet → 4 words; last word is 00080007 with tlast.
